// File: rtl/status_pkg.sv
// Shared constants for the processor status register: flag bit positions and reset value.
package status_pkg;

   localparam int P_C = 0;
   localparam int P_Z = 1;
   localparam int P_I = 2;
   localparam int P_D = 3;
   localparam int P_B = 4;
   localparam int P_U = 5;
   localparam int P_V = 6;
   localparam int P_N = 7;

   localparam logic [7:0] RST_P_DEFAULT = 8'h34;

endpackage

// File: rtl/status_flags_int_sync.sv
// Interrupt pin synchroniser with a registered falling-edge detector on the synchronised level.
module int_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_n,
   output logic level,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Both the chain and the edge history reset to the deasserted level so reset never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_n};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign fall  = prev_q & ~level;

endmodule

// File: rtl/status_flags.sv
// 6502-style status register P downstream of the ALU, with flag strobes, PLP restore,
// push formatting and instruction-boundary IRQ/NMI decision using delayed-I semantics.
module status_flags
   import status_pkg::*;
#(
   parameter logic [7:0]  RST_P       = RST_P_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] alu_result,
   input  logic       alu_of,
   input  logic       alu_cout,
   input  logic       alu_valid,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic       bit_op,
   input  logic [7:0] bit_operand,
   input  logic       set_c,
   input  logic       clr_c,
   input  logic       set_i,
   input  logic       clr_i,
   input  logic       set_d,
   input  logic       clr_d,
   input  logic       clr_v,
   input  logic       plp_load,
   input  logic [7:0] plp_data,
   input  logic       brk_push,
   input  logic       irq_n,
   input  logic       nmi_n,
   input  logic       poll,
   input  logic       int_ack,
   output logic [7:0] p_reg,
   output logic [7:0] push_data,
   output logic       carry_in,
   output logic       dec_en,
   output logic       nmi_take,
   output logic       irq_take
);

   logic [7:0] p_q, p_d;
   logic       irq_level, nmi_fall;
   logic       irq_fall_unused, nmi_level_unused;
   logic [7:0] bits_unused;
   logic       nmi_latch_q, nmi_latch_d;
   logic       last_nmi_q, last_nmi_d;
   logic       i_seen_q, i_seen_d;
   logic       nmi_take_q, nmi_take_d;
   logic       irq_take_q, irq_take_d;

   assign bits_unused = {bit_operand[5:0], plp_data[5:4]};

   int_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_irq_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_n(irq_n),
      .level  (irq_level),
      .fall   (irq_fall_unused)
   );

   int_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_nmi_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_n(nmi_n),
      .level  (nmi_level_unused),
      .fall   (nmi_fall)
   );

   always_comb begin
      p_d = p_q;
      if (plp_load) begin
         p_d = plp_data;
      end else begin
         if (alu_valid) begin
            if (bit_op) begin
               p_d[P_N] = bit_operand[7];
               p_d[P_V] = bit_operand[6];
               p_d[P_Z] = (alu_result == 8'h00);
            end else begin
               if (upd_nz) begin
                  p_d[P_N] = alu_result[7];
                  p_d[P_Z] = (alu_result == 8'h00);
               end
               if (upd_v) p_d[P_V] = alu_of;
            end
            if (upd_c) p_d[P_C] = alu_cout;
         end
         // Strobes override the ALU; a simultaneous set+clr pins the flag to its old value.
         if (set_c & clr_c)      p_d[P_C] = p_q[P_C];
         else if (set_c | clr_c) p_d[P_C] = set_c;
         if (set_i & clr_i)      p_d[P_I] = p_q[P_I];
         else if (set_i | clr_i) p_d[P_I] = set_i;
         if (set_d & clr_d)      p_d[P_D] = p_q[P_D];
         else if (set_d | clr_d) p_d[P_D] = set_d;
         if (clr_v)              p_d[P_V] = 1'b0;
      end
      p_d[P_U] = 1'b1;
      p_d[P_B] = 1'b1;
   end

   always_comb begin
      // A fresh edge beats an acknowledge landing in the same cycle.
      nmi_latch_d = nmi_fall | (nmi_latch_q & ~(int_ack & last_nmi_q));
      last_nmi_d  = last_nmi_q;
      i_seen_d    = i_seen_q;
      nmi_take_d  = 1'b0;
      irq_take_d  = 1'b0;
      if (poll) begin
         nmi_take_d = nmi_latch_q;
         irq_take_d = ~irq_level & ~i_seen_q & ~nmi_latch_q;
         i_seen_d   = p_q[P_I];
         last_nmi_d = nmi_latch_q;
      end else if (int_ack) begin
         last_nmi_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= RST_P;
         nmi_latch_q <= 1'b0;
         last_nmi_q  <= 1'b0;
         i_seen_q    <= 1'b1;
         nmi_take_q  <= 1'b0;
         irq_take_q  <= 1'b0;
      end else begin
         p_q         <= p_d;
         nmi_latch_q <= nmi_latch_d;
         last_nmi_q  <= last_nmi_d;
         i_seen_q    <= i_seen_d;
         nmi_take_q  <= nmi_take_d;
         irq_take_q  <= irq_take_d;
      end
   end

   assign p_reg     = p_q;
   assign push_data = {p_q[P_N], p_q[P_V], 1'b1, brk_push, p_q[P_D], p_q[P_I], p_q[P_Z], p_q[P_C]};
   assign carry_in  = p_q[P_C];
   assign dec_en    = p_q[P_D];
   assign nmi_take  = nmi_take_q;
   assign irq_take  = irq_take_q;

endmodule

// File: tb/tb_status_flags.sv
// Scoreboard bench for status_flags: directed cases then randomized traffic against a flag-level model.
module tb_status_flags;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] alu_result, bit_operand, plp_data;
   logic       alu_of, alu_cout, alu_valid, upd_nz, upd_c, upd_v, bit_op;
   logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, plp_load, brk_push;
   logic       irq_n, nmi_n, poll, int_ack;
   logic [7:0] p_reg, push_data;
   logic       carry_in, dec_en, nmi_take, irq_take;

   typedef struct {
      logic [7:0] p;
      logic [7:0] push;
      logic       nmi;
      logic       irq;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Model state
   logic m_n, m_v, m_d, m_i, m_z, m_c;
   logic m_latch, m_last_nmi, m_iseen, m_nmi_take, m_irq_take;
   logic irq_hist[$];
   logic nmi_hist[$];

   status_flags #(
      .RST_P      (8'h34),
      .SYNC_STAGES(S)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_result (alu_result),
      .alu_of     (alu_of),
      .alu_cout   (alu_cout),
      .alu_valid  (alu_valid),
      .upd_nz     (upd_nz),
      .upd_c      (upd_c),
      .upd_v      (upd_v),
      .bit_op     (bit_op),
      .bit_operand(bit_operand),
      .set_c      (set_c),
      .clr_c      (clr_c),
      .set_i      (set_i),
      .clr_i      (clr_i),
      .set_d      (set_d),
      .clr_d      (clr_d),
      .clr_v      (clr_v),
      .plp_load   (plp_load),
      .plp_data   (plp_data),
      .brk_push   (brk_push),
      .irq_n      (irq_n),
      .nmi_n      (nmi_n),
      .poll       (poll),
      .int_ack    (int_ack),
      .p_reg      (p_reg),
      .push_data  (push_data),
      .carry_in   (carry_in),
      .dec_en     (dec_en),
      .nmi_take   (nmi_take),
      .irq_take   (irq_take)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic resolve(input logic s, input logic c, input logic alu_val,
                                    input logic old);
      if (s && c) return old;
      if (s)      return 1'b1;
      if (c)      return 1'b0;
      return alu_val;
   endfunction

   task automatic model_reset();
      {m_n, m_v, m_d, m_i, m_z, m_c} = 6'b0_0_0_1_0_0;
      m_latch = 0; m_last_nmi = 0; m_iseen = 1; m_nmi_take = 0; m_irq_take = 0;
      irq_hist = {};
      nmi_hist = {};
      repeat (S + 1) begin
         irq_hist.push_back(1'b1);
         nmi_hist.push_back(1'b1);
      end
   endtask

   task automatic model_edge();
      logic an, av, az, ac, irq_lvl, nmi_fall, new_latch, new_last;
      // Pins as seen S clocks late; the edge compares that with one clock earlier.
      irq_lvl  = irq_hist[S-1];
      nmi_fall = nmi_hist[S] && !nmi_hist[S-1];
      new_latch = nmi_fall || (m_latch && !(int_ack && m_last_nmi));
      new_last  = poll ? m_latch : (int_ack ? 1'b0 : m_last_nmi);
      m_nmi_take = poll && m_latch;
      m_irq_take = poll && !irq_lvl && !m_iseen && !m_latch;
      if (poll) m_iseen = m_i;
      m_latch = new_latch;
      m_last_nmi = new_last;
      irq_hist.push_front(irq_n); void'(irq_hist.pop_back());
      nmi_hist.push_front(nmi_n); void'(nmi_hist.pop_back());

      if (plp_load) begin
         {m_n, m_v} = plp_data[7:6];
         {m_d, m_i, m_z, m_c} = plp_data[3:0];
      end else begin
         an = m_n; av = m_v; az = m_z; ac = m_c;
         if (alu_valid) begin
            if (bit_op) begin
               an = bit_operand[7]; av = bit_operand[6]; az = (alu_result == 0);
            end else begin
               if (upd_nz) begin an = alu_result[7]; az = (alu_result == 0); end
               if (upd_v)  av = alu_of;
            end
            if (upd_c) ac = alu_cout;
         end
         m_n = an;
         m_z = az;
         m_v = clr_v ? 1'b0 : av;
         m_c = resolve(set_c, clr_c, ac, m_c);
         m_i = resolve(set_i, clr_i, m_i, m_i);
         m_d = resolve(set_d, clr_d, m_d, m_d);
      end
   endtask

   // Predict the state after the coming rising edge, queue it, then advance to the next falling edge.
   task automatic cycle();
      exp_t e;
      if (!rst_n) model_reset();
      else        model_edge();
      e.p    = {m_n, m_v, 1'b1, 1'b1, m_d, m_i, m_z, m_c};
      e.push = {m_n, m_v, 1'b1, brk_push, m_d, m_i, m_z, m_c};
      e.nmi  = m_nmi_take;
      e.irq  = m_irq_take;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic clear_ctl();
      {alu_valid, upd_nz, upd_c, upd_v, bit_op, alu_of, alu_cout} = '0;
      {set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, plp_load, poll, int_ack} = '0;
      alu_result = 8'h00; bit_operand = 8'h00; plp_data = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         clear_ctl();
         cycle();
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("p_reg", p_reg, e.p);
            check("push_data", push_data, e.push);
            check("carry_in", {7'b0, carry_in}, {7'b0, e.p[0]});
            check("dec_en", {7'b0, dec_en}, {7'b0, e.p[3]});
            check("nmi_take", {7'b0, nmi_take}, {7'b0, e.nmi});
            check("irq_take", {7'b0, irq_take}, {7'b0, e.irq});
         end
      end
   end

   initial begin : stim
      rst_n = 1'b0; irq_n = 1'b1; nmi_n = 1'b1; brk_push = 1'b1;
      clear_ctl();
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // ALU update of every flag: expect 8'h77
      clear_ctl();
      alu_valid = 1; upd_nz = 1; upd_c = 1; upd_v = 1; alu_result = 8'h00; alu_cout = 1; alu_of = 1;
      cycle();
      // Strobe beats ALU carry
      clear_ctl();
      alu_valid = 1; upd_c = 1; alu_cout = 0; set_c = 1;
      cycle();
      // PLP beats clr_c: expect 8'hF3
      clear_ctl();
      plp_load = 1; plp_data = 8'hC3; clr_c = 1;
      cycle();
      // BIT: N,V from operand, Z from result
      clear_ctl();
      plp_load = 1; plp_data = 8'h00;
      cycle();
      clear_ctl();
      alu_valid = 1; bit_op = 1; bit_operand = 8'hC0; alu_result = 8'h00;
      cycle();

      // Delayed-I: blocked at first poll after CLI, taken at the second
      clear_ctl();
      irq_n = 0; set_i = 1;
      cycle();
      clear_ctl(); poll = 1; cycle();
      clear_ctl(); clr_i = 1; cycle();
      idle(3);
      clear_ctl(); poll = 1; cycle();
      idle(1);
      clear_ctl(); poll = 1; cycle();
      idle(1);

      // NMI has priority over a pending IRQ
      nmi_n = 0;
      idle(4);
      clear_ctl(); poll = 1; cycle();
      clear_ctl(); int_ack = 1; set_i = 1; cycle();
      nmi_n = 1;
      idle(4);

      // Pending NMI discarded by reset
      nmi_n = 0;
      idle(4);
      rst_n = 0; nmi_n = 1;
      idle(1);
      rst_n = 1;
      clear_ctl(); poll = 1; cycle();
      idle(2);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst_n       = ($urandom_range(0, 399) != 0);
         alu_valid   = $urandom_range(0, 1);
         upd_nz      = $urandom_range(0, 1);
         upd_c       = $urandom_range(0, 1);
         upd_v       = $urandom_range(0, 1);
         bit_op      = ($urandom_range(0, 5) == 0);
         alu_result  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
         bit_operand = 8'($urandom());
         alu_of      = $urandom_range(0, 1);
         alu_cout    = $urandom_range(0, 1);
         set_c       = ($urandom_range(0, 7) == 0);
         clr_c       = ($urandom_range(0, 7) == 0);
         set_i       = ($urandom_range(0, 7) == 0);
         clr_i       = ($urandom_range(0, 5) == 0);
         set_d       = ($urandom_range(0, 9) == 0);
         clr_d       = ($urandom_range(0, 9) == 0);
         clr_v       = ($urandom_range(0, 9) == 0);
         plp_load    = ($urandom_range(0, 15) == 0);
         plp_data    = 8'($urandom());
         brk_push    = $urandom_range(0, 1);
         poll        = ($urandom_range(0, 3) == 0);
         int_ack     = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 19) == 0) irq_n = ~irq_n;
         if ($urandom_range(0, 14) == 0) nmi_n = ~nmi_n;
         cycle();
      end
      rst_n = 1;
      idle(2);

      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
